// File: rtl/iq_mod_tx.sv
// QPSK modulator: 2-bit Gray symbols phase-shift a 16-bit NCO carrier
// that drives a single registered output pin.
module iq_mod_tx #(
    parameter logic [15:0] FCW        = 16'h1000,
    parameter int          SYM_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_in_n,
    input  logic        enable,
    input  logic [15:0] phase_offset,
    input  logic [1:0]  sym_data,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic        sig,
    output logic        sym_stb,
    output logic        underrun,
    output logic        busy
);

    localparam int CW = $clog2(SYM_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [15:0] acc, acc_nx;
    logic [15:0] sym_ph, sym_ph_nx;
    logic [15:0] phase_sum;
    logic [CW-1:0] cnt, cnt_nx;
    logic        sig_nx, stb_nx, und_nx;
    logic        last, xfer;

    function automatic logic [15:0] gray_phase(input logic [1:0] s);
        unique case (s)
            2'b00:   return 16'h0000;
            2'b01:   return 16'h4000;
            2'b11:   return 16'h8000;
            default: return 16'hC000;
        endcase
    endfunction

    assign last      = (cnt == '0);
    assign sym_ready = enable && (state == IDLE || (state == RUN && last));
    assign xfer      = sym_valid && sym_ready;
    assign busy      = (state == RUN);
    assign phase_sum = acc + sym_ph + phase_offset;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (xfer) state_nx = RUN;
            RUN:  if (last && !xfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // On the final edge of a symbol sig still uses the old phase;
    // acc keeps running across back-to-back symbols.
    always_comb begin
        acc_nx    = acc;
        sym_ph_nx = sym_ph;
        cnt_nx    = cnt;
        sig_nx    = 1'b0;
        stb_nx    = xfer;
        und_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                acc_nx = '0;
                if (xfer) begin
                    sym_ph_nx = gray_phase(sym_data);
                    cnt_nx    = CW'(SYM_CYCLES - 1);
                end
            end
            RUN: begin
                sig_nx = phase_sum[15];
                acc_nx = acc + FCW;
                if (!last) begin
                    cnt_nx = cnt - CW'(1);
                end else if (xfer) begin
                    sym_ph_nx = gray_phase(sym_data);
                    cnt_nx    = CW'(SYM_CYCLES - 1);
                end else begin
                    und_nx = enable;
                end
            end
            default: acc_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            acc      <= '0;
            sym_ph   <= '0;
            cnt      <= '0;
            sig      <= 1'b0;
            sym_stb  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            acc      <= acc_nx;
            sym_ph   <= sym_ph_nx;
            cnt      <= cnt_nx;
            sig      <= sig_nx;
            sym_stb  <= stb_nx;
            underrun <= und_nx;
        end
    end

endmodule

// File: tb/tb_iq_mod_tx.sv
// Bench for iq_mod_tx: directed and random symbol streams checked
// against an ideal NCO phase model.
module tb_iq_mod_tx;

    localparam logic [15:0] FCW = 16'h1000;
    localparam int          SYM = 32;
    localparam int          NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] phase_offset = '0;
    logic [1:0]  sym_data = '0;
    logic        sym_valid = 1'b0;
    logic        sym_ready, sig, sym_stb, underrun, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iq_mod_tx #(.FCW(FCW), .SYM_CYCLES(SYM)) dut (
        .clk(clk),
        .rst_in_n(rst_in_n),
        .enable(enable),
        .phase_offset(phase_offset),
        .sym_data(sym_data),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sig(sig),
        .sym_stb(sym_stb),
        .underrun(underrun),
        .busy(busy)
    );

    function automatic int ph_of(input logic [1:0] s);
        case (s)
            2'b00:   return 'h0000;
            2'b01:   return 'h4000;
            2'b11:   return 'h8000;
            default: return 'hC000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected sig on edge n of a stream that started with acc=0:
    // MSB of (FCW*(n-1) + symbol phase + offset) mod 2^16.
    task automatic run_stream(input logic [1:0] syms[$], input logic [15:0] off0,
                              input logic [15:0] off1, input int chg_at,
                              input logic en_end, input int abort_at);
        int nsym;
        int total;
        nsym = syms.size();
        total = nsym * SYM;
        phase_offset = off0;
        enable = 1'b1;
        sym_data = syms[0];
        sym_valid = 1'b1;
        #1;
        chk("ready_idle", sym_ready, 1'b1);
        for (int n = 0; n <= total; n++) begin
            @(posedge clk);
            #1;
            if (n >= 1) begin
                logic [15:0] s;
                int m;
                m = n - 1;
                s = 16'(int'(FCW) * m + ph_of(syms[m / SYM])
                        + int'((n > chg_at) ? off1 : off0));
                chk("sig", sig, s[15]);
            end
            chk("sym_stb", sym_stb, (n % SYM == 0) && (n < total));
            chk("busy", busy, n < total);
            chk("underrun", underrun, (n == total) && en_end);
            if (n == abort_at) begin
                sym_valid = 1'b0;
                rst_in_n = 1'b0;
                #1;
                chk("rst_sig", sig, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_stb", sym_stb, 1'b0);
                chk("rst_und", underrun, 1'b0);
                chk("rst_ready", sym_ready, enable);
                @(posedge clk);
                #1;
                chk("rst_hold_busy", busy, 1'b0);
                rst_in_n = 1'b1;
                return;
            end
            if (n == chg_at) phase_offset = off1;
            if ((n % SYM == 0) && (n < total)) begin
                if (n / SYM + 1 < nsym) begin
                    sym_data = syms[n / SYM + 1];
                end else begin
                    sym_valid = 1'b0;
                    enable = en_end;
                end
            end
            #1;
            chk("sym_ready", sym_ready,
                enable && ((n < total) ? ((n + 1) % SYM == 0) : 1'b1));
        end
        @(posedge clk);
        #1;
        chk("idle_sig", sig, 1'b0);
        chk("idle_und", underrun, 1'b0);
        chk("idle_busy", busy, 1'b0);
        enable = 1'b1;
    endtask

    initial begin
        logic [1:0] q[$];
        int tot;
        #22;
        chk("reset_sig", sig, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_stb", sym_stb, 1'b0);
        chk("reset_und", underrun, 1'b0);
        rst_in_n = 1'b1;
        @(posedge clk);
        #1;

        q = '{2'b00};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b1, -1);
        q = '{2'b01};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b1, -1);
        q = '{2'b11};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b1, -1);
        q = '{2'b00};
        run_stream(q, 16'h8000, 16'h8000, NEVER, 1'b1, -1);
        q = '{2'b00, 2'b11};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b1, -1);
        q = '{2'b10};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b0, -1);

        q = '{2'b01};
        run_stream(q, 16'h1234, 16'h1234, NEVER, 1'b1, 10);
        @(posedge clk);
        #1;
        q = '{2'b00};
        run_stream(q, 16'h0000, 16'h0000, NEVER, 1'b1, -1);

        enable = 1'b0;
        sym_valid = 1'b1;
        #1;
        chk("ready_disabled", sym_ready, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_xfer_busy", busy, 1'b0);
            chk("no_xfer_stb", sym_stb, 1'b0);
        end
        sym_valid = 1'b0;
        enable = 1'b1;

        q = '{2'b00, 2'b01, 2'b11, 2'b10};
        run_stream(q, 16'($urandom), 16'($urandom), NEVER, 1'b1, -1);

        repeat (8) begin
            q.delete();
            repeat ($urandom_range(1, 4)) q.push_back(2'($urandom));
            tot = q.size() * SYM;
            run_stream(q, 16'($urandom), 16'($urandom),
                       int'($urandom_range(1, tot)), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
